// File: rtl/io_port_bank.sv
// io_port_bank: N_IN synchronised input ports, N_OUT output latches and a register-mapped read path.
// Defining IO_PORT_BANK_IRQ_EN adds per-input change flags (STATUS), MASK and the maskable irq.
module io_port_bank #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    io_sel,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd_data,
    input  logic [N_IN*DATA_W-1:0]  field_in,
    output logic [N_OUT*DATA_W-1:0] field_out,
    output logic                    irq
);

    logic                         wr;
    logic [N_IN-1:0][DATA_W-1:0]  sync1;
    logic [N_IN-1:0][DATA_W-1:0]  sync2;
    logic [N_OUT-1:0][DATA_W-1:0] out_q;

    assign wr        = io_sel & wr_en;
    assign field_out = out_q;

    // Two-flop synchroniser for the asynchronous external inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= field_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (wr) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (addr == ADDR_W'(N_IN + j)) out_q[j] <= wr_data;
            end
        end
    end

`ifdef IO_PORT_BANK_IRQ_EN
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(N_IN + N_OUT);
    localparam logic [ADDR_W-1:0] ADDR_MASK   = ADDR_W'(N_IN + N_OUT + 1);

    logic [N_IN-1:0][DATA_W-1:0] prev;
    logic [1:0]                  arm_cnt;
    logic                        armed;
    logic [N_IN-1:0]             flags;
    logic [N_IN-1:0]             mask;
    logic [N_IN-1:0]             chg;
    logic [N_IN-1:0]             clr;

    // Arming holds off detection until the synchroniser has filled after reset.
    assign armed = (arm_cnt == 2'd3);

    always_comb begin
        chg = '0;
        for (int i = 0; i < N_IN; i++) begin
            chg[i] = armed && (sync2[i] != prev[i]);
        end
    end

    assign clr = (wr && (addr == ADDR_STATUS)) ? wr_data[N_IN-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            arm_cnt <= 2'd0;
            flags   <= '0;
            mask    <= '0;
        end else begin
            prev <= sync2;
            if (!armed) arm_cnt <= arm_cnt + 2'd1;
            // A change event in the same cycle as its W1C keeps the flag set.
            flags <= chg | (flags & ~clr);
            if (wr && (addr == ADDR_MASK)) mask <= wr_data[N_IN-1:0];
        end
    end

    assign irq = |(flags & mask);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (io_sel) begin
            for (int i = 0; i < N_IN; i++) begin
                if (addr == ADDR_W'(i)) rd_data = sync2[i];
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (addr == ADDR_W'(N_IN + j)) rd_data = out_q[j];
            end
`ifdef IO_PORT_BANK_IRQ_EN
            if (addr == ADDR_STATUS) rd_data[N_IN-1:0] = flags;
            if (addr == ADDR_MASK)   rd_data[N_IN-1:0] = mask;
`endif
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank (N_IN=2, N_OUT=2); covers both IO_PORT_BANK_IRQ_EN builds.
module tb_io_port_bank;
    localparam int DATA_W = 8;
    localparam int N_IN   = 2;
    localparam int N_OUT  = 2;
    localparam int ADDR_W = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    io_sel;
    logic                    wr_en;
    logic [ADDR_W-1:0]       addr;
    logic [DATA_W-1:0]       wr_data;
    logic [DATA_W-1:0]       rd_data;
    logic [N_IN*DATA_W-1:0]  field_in;
    logic [N_OUT*DATA_W-1:0] field_out;
    logic                    irq;

    io_port_bank #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .io_sel(io_sel), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .field_in(field_in),
        .field_out(field_out), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", obs, 32'hDEAD_BEEF);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        io_sel = 1'b1; wr_en = 1'b1; addr = a; wr_data = d;
        tick();
        io_sel = 1'b0; wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        io_sel = 1'b1; wr_en = 1'b0; addr = a;
        sb_push(tag, exp);
        #1;
        sb_pop_check(32'(rd_data));
        io_sel = 1'b0;
    endtask

    task automatic pins_chk(input string tag, input logic [31:0] exp_out, input logic exp_irq);
        sb_push({tag, "_out"}, exp_out);
        sb_push({tag, "_irq"}, 32'(exp_irq));
        sb_pop_check(32'(field_out));
        sb_pop_check(32'(irq));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; io_sel = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
        field_in = 16'hA55A;
        repeat (3) tick();

        // reset state
        pins_chk("rst", 32'h0, 1'b0);
        sb_push("rst_rd_idle", 32'h0);
        sb_pop_check(32'(rd_data));
        rd_chk("rst_in0", 8'd0, 32'h0);

        rst_n = 1'b1;
        tick();
        rd_chk("in0_edge1", 8'd0, 32'h0);
        tick();
        rd_chk("in0_edge2", 8'd0, 32'h5A);
        rd_chk("in1_edge2", 8'd1, 32'hA5);
        repeat (3) tick();
        rd_chk("status_after_rst", 8'd4, 32'h0);
        pins_chk("post_rst", 32'h0, 1'b0);

        // output latches
        reg_wr(8'd2, 8'h3C);
        pins_chk("wr_out0", 32'h003C, 1'b0);
        reg_wr(8'd3, 8'hC3);
        pins_chk("wr_out1", 32'hC33C, 1'b0);
        rd_chk("rd_out0", 8'd2, 32'h3C);
        rd_chk("rd_out1", 8'd3, 32'hC3);
        io_sel = 1'b0; wr_en = 1'b1; addr = 8'd2; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        pins_chk("wr_nosel", 32'hC33C, 1'b0);

        // unmapped address
        reg_wr(8'h10, 8'h77);
        pins_chk("wr_unmapped", 32'hC33C, 1'b0);
        rd_chk("rd_ff", 8'hFF, 32'h0);
        rd_chk("rd_unmapped", 8'h06, 32'h0);

        // input latency
        field_in = 16'h1234;
        tick();
        rd_chk("in0_lat1", 8'd0, 32'h5A);
        tick();
        rd_chk("in0_lat2", 8'd0, 32'h34);
        rd_chk("in1_lat2", 8'd1, 32'h12);

`ifdef IO_PORT_BANK_IRQ_EN
        repeat (3) tick();
        reg_wr(8'd4, 8'hFF);
        rd_chk("status_clr_all", 8'd4, 32'h0);
        reg_wr(8'd5, 8'h01);
        rd_chk("mask_rd", 8'd5, 32'h01);
        field_in = 16'h1200;
        repeat (3) tick();
        reg_wr(8'd4, 8'hFF);
        field_in = 16'h1201;
        tick();
        tick();
        rd_chk("status_edge2", 8'd4, 32'h0);
        pins_chk("irq_edge2", 32'hC33C, 1'b0);
        tick();
        rd_chk("status_edge3", 8'd4, 32'h01);
        pins_chk("irq_edge3", 32'hC33C, 1'b1);
        reg_wr(8'd4, 8'h01);
        rd_chk("status_w1c", 8'd4, 32'h0);
        pins_chk("irq_w1c", 32'hC33C, 1'b0);

        // masked flag
        field_in = 16'h0001;
        repeat (3) tick();
        rd_chk("status_masked", 8'd4, 32'h02);
        pins_chk("irq_masked", 32'hC33C, 1'b0);
        reg_wr(8'd5, 8'h03);
        pins_chk("irq_unmask", 32'hC33C, 1'b1);
        reg_wr(8'd4, 8'hFF);
        rd_chk("status_clr2", 8'd4, 32'h0);

        // set wins over W1C in the same cycle
        field_in = 16'h0002;
        tick();
        tick();
        reg_wr(8'd4, 8'h01);
        rd_chk("status_collide", 8'd4, 32'h01);
        pins_chk("irq_collide", 32'hC33C, 1'b1);
        reg_wr(8'd5, 8'hFF);
        rd_chk("mask_upper", 8'd5, 32'h03);
        reg_wr(8'd5, 8'h00);
        pins_chk("irq_mask0", 32'hC33C, 1'b0);
        rd_chk("status_kept", 8'd4, 32'h01);
`else
        field_in = 16'hFFFF;
        repeat (4) tick();
        field_in = 16'h0000;
        repeat (4) tick();
        pins_chk("noirq_toggle", 32'hC33C, 1'b0);
        rd_chk("noirq_status", 8'd4, 32'h0);
        reg_wr(8'd5, 8'hFF);
        rd_chk("noirq_mask", 8'd5, 32'h0);
        reg_wr(8'd4, 8'hFF);
        pins_chk("noirq_wr", 32'hC33C, 1'b0);
        rd_chk("noirq_in0", 8'd0, 32'h00);
`endif

        // asynchronous reset mid-operation
        field_in = 16'h6699;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        pins_chk("midrst", 32'h0, 1'b0);
        rd_chk("midrst_in0", 8'd0, 32'h0);
        rd_chk("midrst_out0", 8'd2, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        pins_chk("after_midrst", 32'h0, 1'b0);
        tick();
        rd_chk("in0_after_midrst", 8'd0, 32'h99);
        repeat (3) tick();
        rd_chk("status_after_midrst", 8'd4, 32'h0);

        if (sb_q.size() != 0) check_val("sb_leftover", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
